// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - defaults and address-legality helpers for reg_file
`include "reg_defs.vh"

package reg_file_pkg;

  localparam int RF_WIDTH_DEF = `RF_WIDTH_DEFAULT;
  localparam int RF_DEPTH_DEF = `RF_DEPTH_DEFAULT;
  localparam bit RF_ZERO_REG_DEF = `RF_ZERO_REG_DEFAULT;
  localparam bit RF_BYPASS_DEF = `RF_BYPASS_DEFAULT;

  // An address names a physical register only below DEPTH.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

  // Writable / lockable: in range and not the hard-wired zero register.
  function automatic logic addr_writable(input int unsigned addr, input int unsigned depth,
                                         input bit zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/reg_defs.vh
// rtl/reg_defs.vh - shared defaults and address-width macro for the register file
`ifndef REG_DEFS_VH
`define REG_DEFS_VH

`define RF_WIDTH_DEFAULT 16
`define RF_DEPTH_DEFAULT 8
`define RF_ZERO_REG_DEFAULT 1'b1
`define RF_BYPASS_DEFAULT 1'b1

// Address width for a given depth, never narrower than one bit.
`define RF_CLOG2(d) (($clog2(d) < 1) ? 1 : $clog2(d))

`endif

// File: rtl/reg_read_port.sv
// rtl/reg_read_port.sv - capture register, valid flag and tri-state driver for one read port
module reg_read_port #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic             blocked,
  input  logic [WIDTH-1:0] rdata,
  input  logic             oe,
  output logic             valid,
  output tri   [WIDTH-1:0] d
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;

  // Capture only on an unblocked request; valid marks a fresh capture for one cycle.
  always_comb begin
    q_d     = q_q;
    valid_d = 1'b0;
    if (re && !blocked) begin
      q_d     = rdata;
      valid_d = 1'b1;
    end
  end

  // Capture state clears immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  // Output enable only gates the driver, never the capture.
  assign d = oe ? q_q : {WIDTH{1'bz}};

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file with write port, two read ports and busy scoreboard
`include "reg_defs.vh"

module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH_DEF,
  parameter int DEPTH    = RF_DEPTH_DEF,
  parameter bit ZERO_REG = RF_ZERO_REG_DEF,
  parameter bit BYPASS   = RF_BYPASS_DEF,
  localparam int AW      = `RF_CLOG2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  input  logic             oe_a,
  input  logic             oe_b,
  input  logic             lock,
  input  logic [AW-1:0]    lock_addr,
  output tri   [WIDTH-1:0] dA,
  output tri   [WIDTH-1:0] dB,
  output logic             valid_a,
  output logic             valid_b,
  output logic [DEPTH-1:0] busy,
  output logic             stall
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  logic             wr_ok, lock_ok;
  logic             fwd_a, fwd_b;
  logic             blocked_a, blocked_b;
  logic [WIDTH-1:0] rval_a, rval_b;

  // Legality of this cycle's write and lock.
  always_comb begin
    wr_ok   = we && addr_writable(int'(waddr), DEPTH, ZERO_REG);
    lock_ok = lock && addr_writable(int'(lock_addr), DEPTH, ZERO_REG);
  end

  // Read value, forwarding and blocking for both ports.
  always_comb begin
    fwd_a     = BYPASS && wr_ok && (waddr == raddr_a);
    fwd_b     = BYPASS && wr_ok && (waddr == raddr_b);
    rval_a    = '0;
    rval_b    = '0;
    blocked_a = 1'b0;
    blocked_b = 1'b0;
    if (addr_writable(int'(raddr_a), DEPTH, ZERO_REG)) begin
      rval_a    = fwd_a ? wdata : regs_q[raddr_a];
      blocked_a = busy_q[raddr_a] && !fwd_a;
    end
    if (addr_writable(int'(raddr_b), DEPTH, ZERO_REG)) begin
      rval_b    = fwd_b ? wdata : regs_q[raddr_b];
      blocked_b = busy_q[raddr_b] && !fwd_b;
    end
  end

  // Next register contents and scoreboard; a lock overrides a same-address write clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
      busy_d[waddr] = 1'b0;
    end
    if (lock_ok) begin
      busy_d[lock_addr] = 1'b1;
    end
  end

  // Register array and scoreboard state with immediate reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy  = busy_q;
  assign stall = (re_a && blocked_a) || (re_b && blocked_b);

  reg_read_port #(.WIDTH(WIDTH)) u_port_a (
    .clk     (clk),
    .rst     (rst),
    .re      (re_a),
    .blocked (blocked_a),
    .rdata   (rval_a),
    .oe      (oe_a),
    .valid   (valid_a),
    .d       (dA)
  );

  reg_read_port #(.WIDTH(WIDTH)) u_port_b (
    .clk     (clk),
    .rst     (rst),
    .re      (re_b),
    .blocked (blocked_b),
    .rdata   (rval_b),
    .oe      (oe_b),
    .valid   (valid_b),
    .d       (dB)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        re_a, re_b;
  logic [2:0]  raddr_a, raddr_b;
  logic        oe_a, oe_b;
  logic        lock;
  logic [2:0]  lock_addr;

  wire  [15:0] dA, dB;
  logic        valid_a, valid_b;
  logic [7:0]  busy;
  logic        stall;

  wire  [15:0] nb_dA, nb_dB;
  logic        nb_valid_a, nb_valid_b;
  logic [5:0]  nb_busy;
  logic        nb_stall;

  int checks;
  int failures;

  reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .oe_a(oe_a), .oe_b(oe_b), .lock(lock), .lock_addr(lock_addr),
    .dA(dA), .dB(dB), .valid_a(valid_a), .valid_b(valid_b),
    .busy(busy), .stall(stall)
  );

  reg_file #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .oe_a(oe_a), .oe_b(oe_b), .lock(lock), .lock_addr(lock_addr),
    .dA(nb_dA), .dB(nb_dB), .valid_a(nb_valid_a), .valid_b(nb_valid_b),
    .busy(nb_busy), .stall(nb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;
    re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
    oe_a = 1'b0; oe_b = 1'b0; lock = 1'b0; lock_addr = '0;
    #12;

    // Reset state
    checks++;
    assert (dA === 16'hzzzz) else begin
      failures++;
      $error("FAIL rst_dA_z observed=%h expected=zzzz", dA);
    end
    chk("rst_busy", {8'h00, busy}, 16'h0000);
    chk("rst_valid_a", {15'h0, valid_a}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // First read after reset on r3
    oe_a = 1'b1; oe_b = 1'b1;
    re_a = 1'b1; raddr_a = 3'd3;
    tick();
    re_a = 1'b0;
    chk("r3_dA", dA, 16'h0000);
    chk("r3_valid_a", {15'h0, valid_a}, 16'h0001);
    oe_a = 1'b0;
    #1;
    checks++;
    assert (dA === 16'hzzzz) else begin
      failures++;
      $error("FAIL oe_off_dA_z observed=%h expected=zzzz", dA);
    end
    oe_a = 1'b1;

    // Write r5 then read it on both ports
    we = 1'b1; waddr = 3'd5; wdata = 16'hBEEF;
    tick();
    we = 1'b0;
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd5;
    tick();
    re_a = 1'b0; re_b = 1'b0;
    chk("r5_dA", dA, 16'hBEEF);
    chk("r5_dB", dB, 16'hBEEF);
    chk("r5_valid_b", {15'h0, valid_b}, 16'h0001);
    chk("r5_nb_dA", nb_dA, 16'hBEEF);

    // Bypass vs no-bypass on r2
    we = 1'b1; waddr = 3'd2; wdata = 16'h1111;
    tick();
    wdata = 16'h1234;
    re_a = 1'b1; raddr_a = 3'd2;
    tick();
    we = 1'b0; re_a = 1'b0;
    chk("byp_dA", dA, 16'h1234);
    chk("nobyp_dA", nb_dA, 16'h1111);

    // Lock r4, blocked read on B
    lock = 1'b1; lock_addr = 3'd4;
    tick();
    lock = 1'b0;
    chk("lock_busy", {8'h00, busy}, 16'h0010);
    re_b = 1'b1; raddr_b = 3'd4;
    #1;
    chk("lock_stall", {15'h0, stall}, 16'h0001);
    tick();
    re_b = 1'b0;
    chk("lock_valid_b", {15'h0, valid_b}, 16'h0000);
    chk("lock_dB_hold", dB, 16'hBEEF);
    we = 1'b1; waddr = 3'd4; wdata = 16'h00AA;
    tick();
    we = 1'b0;
    chk("wr_clears_busy", {8'h00, busy}, 16'h0000);
    re_b = 1'b1; raddr_b = 3'd4;
    #1;
    chk("unlock_stall", {15'h0, stall}, 16'h0000);
    tick();
    re_b = 1'b0;
    chk("unlock_dB", dB, 16'h00AA);
    chk("unlock_valid_b", {15'h0, valid_b}, 16'h0001);

    // Lock and write same address in one cycle: lock wins
    we = 1'b1; waddr = 3'd1; wdata = 16'h0101;
    lock = 1'b1; lock_addr = 3'd1;
    tick();
    we = 1'b0; lock = 1'b0;
    chk("lock_wins_busy", {8'h00, busy}, 16'h0002);
    we = 1'b1; waddr = 3'd1; wdata = 16'h0202;
    tick();
    we = 1'b0;
    chk("lock_wins_clear", {8'h00, busy}, 16'h0000);

    // Zero register: write and lock r0 are ignored
    we = 1'b1; waddr = 3'd0; wdata = 16'hFFFF;
    lock = 1'b1; lock_addr = 3'd0;
    tick();
    we = 1'b0; lock = 1'b0;
    chk("zero_busy", {8'h00, busy}, 16'h0000);
    re_a = 1'b1; raddr_a = 3'd0;
    #1;
    chk("zero_stall", {15'h0, stall}, 16'h0000);
    tick();
    re_a = 1'b0;
    chk("zero_dA", dA, 16'h0000);

    // Out-of-range on DEPTH=6 instance
    we = 1'b1; waddr = 3'd7; wdata = 16'h7777;
    tick();
    we = 1'b0;
    re_a = 1'b1; raddr_a = 3'd5;
    tick();
    chk("nb_pre_dA", nb_dA, 16'hBEEF);
    raddr_a = 3'd7;
    tick();
    re_a = 1'b0;
    chk("r7_dA", dA, 16'h7777);
    chk("nb_r7_dA", nb_dA, 16'h0000);
    lock = 1'b1; lock_addr = 3'd6;
    tick();
    lock = 1'b0;
    chk("nb_illegal_lock", {10'h000, nb_busy}, 16'h0000);
    chk("r6_lock_busy", {8'h00, busy}, 16'h0040);

    // Asynchronous reset between edges
    we = 1'b1; waddr = 3'd3; wdata = 16'h3333;
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd5;
    tick();
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;
    chk("pre_rst_valid_a", {15'h0, valid_a}, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {8'h00, busy}, 16'h0000);
    chk("arst_valid_a", {15'h0, valid_a}, 16'h0000);
    chk("arst_dA", dA, 16'h0000);
    chk("arst_dB", dB, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd5;
    tick();
    re_a = 1'b0; re_b = 1'b0;
    chk("post_rst_r3", dA, 16'h0000);
    chk("post_rst_r5", dB, 16'h0000);
    chk("post_rst_valid_b", {15'h0, valid_b}, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
